// File: rtl/rng_pkg.sv
// Shared defaults and helpers for the random range sampler.
//   WidthDef  : bits per candidate word
//   MaxDef    : exclusive upper bound of accepted values
//   DepthDef  : output FIFO depth
//   CntWDef   : reject counter width
//   ptr_w()   : FIFO address width for a given depth
package rng_pkg;

  localparam int unsigned WidthDef = 3;
  localparam int unsigned MaxDef   = 6;
  localparam int unsigned DepthDef = 2;
  localparam int unsigned CntWDef  = 16;

  // Address width of a FIFO of the given depth; never below 1 bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   push/din : write din when not full
//   pop      : drop the head entry when not empty
//   dout     : head entry, valid whenever !empty
//   full     : no free entry
//   empty    : no stored entry
module sync_fifo_fwft
  import rng_pkg::*;
#(
  parameter int unsigned W     = 3,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam logic [PW:0] PtrOne = {{PW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW:0]  wr_q, rd_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    do_push = push && !full;
    do_pop  = pop && !empty;
    dout    = mem_q[rd_q[PW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PtrOne;
      if (do_pop)  rd_q <= rd_q + PtrOne;
    end
  end

  // Storage needs no reset; the pointers decide what is visible.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[PW-1:0]] <= din;
  end

endmodule

// File: rtl/rng_range_sampler.sv
// Packs random bits into WIDTH-bit candidates and rejection-samples them so
// accepted values are uniform over 0..MAX-1, buffered in a FWFT FIFO.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bit_in     : random bit from the LFSR
//   bit_valid  : bit_in meaningful this cycle
//   bit_ready  : a bit is accepted this cycle (FIFO not full)
//   out_value  : FIFO head value
//   out_valid  : FIFO not empty
//   out_ready  : consumer takes out_value this cycle
//   reject_cnt : saturating count of rejected candidates
module rng_range_sampler
  import rng_pkg::*;
#(
  parameter int unsigned WIDTH = WidthDef,
  parameter int unsigned MAX   = MaxDef,
  parameter int unsigned DEPTH = DepthDef,
  parameter int unsigned CNT_W = CntWDef
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [WIDTH-1:0] out_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] reject_cnt
);

  if (WIDTH < 2 || WIDTH > 30 || MAX < 2 || MAX > (1 << WIDTH) || DEPTH < 2 ||
      (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
    $fatal(1, "rng_range_sampler: illegal WIDTH/MAX/DEPTH");
  end

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0]  LastCnt = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CntOne  = CW'(1);
  localparam logic [WIDTH:0] MaxVal  = (WIDTH + 1)'(MAX);

  logic [WIDTH-2:0] sr_q;
  logic [CW-1:0]    cnt_q;
  logic [CNT_W-1:0] rej_q;

  logic             full, empty;
  logic             bit_acc, word_done, cand_ok, push, reject;
  logic [WIDTH-1:0] candidate;

  always_comb begin
    bit_acc   = bit_valid && !full;
    word_done = bit_acc && (cnt_q == LastCnt);
    // First bit of a word ends up as the MSB.
    candidate = {sr_q, bit_in};
    cand_ok   = ({1'b0, candidate} < MaxVal);
    push      = word_done && cand_ok;
    reject    = word_done && !cand_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
      rej_q <= '0;
    end else begin
      if (bit_acc) begin
        sr_q  <= candidate[WIDTH-2:0];
        cnt_q <= word_done ? '0 : cnt_q + CntOne;
      end
      if (reject && (rej_q != '1)) rej_q <= rej_q + CNT_W'(1);
    end
  end

  sync_fifo_fwft #(
    .W     (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (out_ready),
    .din   (candidate),
    .dout  (out_value),
    .full  (full),
    .empty (empty)
  );

  // full/empty come straight from the pointer registers, so neither
  // handshake output depends combinationally on any input.
  always_comb begin
    bit_ready  = !full;
    out_valid  = !empty;
    reject_cnt = rej_q;
  end

endmodule

// File: tb/tb_rng_range_sampler.sv
module tb_rng_range_sampler;

  localparam int Width = 3;
  localparam int Max   = 6;
  localparam int Depth = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             bit_in = 1'b0;
  logic             bit_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic             bit_ready, out_valid;
  logic [Width-1:0] out_value;
  logic [15:0]      reject_cnt;
  logic             s_bit_ready, s_out_valid;
  logic [Width-1:0] s_out_value;
  logic [1:0]       s_reject_cnt;

  always #5 clk = ~clk;

  rng_range_sampler dut (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .out_value  (out_value),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .reject_cnt (reject_cnt)
  );

  rng_range_sampler #(.CNT_W(2)) dut_sat (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (s_bit_ready),
    .out_value  (s_out_value),
    .out_valid  (s_out_valid),
    .out_ready  (out_ready),
    .reject_cnt (s_reject_cnt)
  );

  // Behavioural model: a queue of accepted values and an arithmetic word builder.
  int m_q[$];
  int m_acc, m_nbits, m_rej, m_words;
  int tests, fails;
  int hist[8];
  bit soak_on;

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_update(input bit r, input bit bv, input bit b, input bit ordy);
    bit accepted;
    if (r) begin
      m_q.delete();
      m_acc = 0;
      m_nbits = 0;
      m_rej = 0;
      return;
    end
    accepted = bv && (m_q.size() < Depth);
    if (ordy && m_q.size() > 0) void'(m_q.pop_front());
    if (accepted) begin
      m_acc = m_acc * 2 + int'(b);
      m_nbits++;
      if (m_nbits == Width) begin
        if (m_acc < Max) m_q.push_back(m_acc);
        else m_rej++;
        m_acc = 0;
        m_nbits = 0;
        m_words++;
      end
    end
  endtask

  task automatic compare();
    check("out_valid", int'(out_valid), int'(m_q.size() > 0));
    check("bit_ready", int'(bit_ready), int'(m_q.size() < Depth));
    if (m_q.size() > 0) check("out_value", int'(out_value), m_q[0]);
    if (out_valid) check("out_value_in_range", int'(out_value < Width'(Max)), 1);
    check("reject_cnt", int'(reject_cnt), sat(m_rej, 65535));
    check("sat_reject_cnt", int'(s_reject_cnt), sat(m_rej, 3));
    check("sat_out_valid", int'(s_out_valid), int'(m_q.size() > 0));
    check("sat_bit_ready", int'(s_bit_ready), int'(m_q.size() < Depth));
  endtask

  // One clock cycle: drive, advance the model, sample 1 time unit after the edge.
  task automatic step(input bit r, input bit bv, input bit b, input bit ordy);
    if (soak_on && out_valid && ordy && !r) hist[out_value]++;
    rst = r;
    bit_valid = bv;
    bit_in = b;
    out_ready = ordy;
    model_update(r, bv, b, ordy);
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic send3(input bit b2, input bit b1, input bit b0, input bit ordy);
    step(1'b0, 1'b1, b2, ordy);
    step(1'b0, 1'b1, b1, ordy);
    step(1'b0, 1'b1, b0, ordy);
  endtask

  logic [15:0] lfsr;
  int iter;

  initial begin
    tests = 0;
    fails = 0;
    soak_on = 1'b0;
    m_words = 0;
    foreach (hist[i]) hist[i] = 0;
    model_update(1'b1, 1'b0, 1'b0, 1'b0);

    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_bit_ready", int'(bit_ready), 1);
    check("reset_reject_cnt", int'(reject_cnt), 0);

    // Basic pack: 1,0,1 -> 5, valid for one cycle
    send3(1'b1, 1'b0, 1'b1, 1'b1);
    check("basic_model", m_q.size() > 0 ? m_q[0] : -1, 5);
    check("basic_value", int'(out_value), 5);
    check("basic_valid", int'(out_valid), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("basic_valid_drop", int'(out_valid), 0);
    check("basic_reject", int'(reject_cnt), 0);

    // Rejection: 7 discarded, then 2
    send3(1'b1, 1'b1, 1'b1, 1'b1);
    check("rej_no_output", int'(out_valid), 0);
    check("rej_count", int'(reject_cnt), 1);
    check("rej_model", m_rej, 1);
    send3(1'b0, 1'b1, 1'b0, 1'b1);
    check("rej_next_value", int'(out_value), 2);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Backpressure: 1 and 3 fill the FIFO, 4 is held off
    send3(1'b0, 1'b0, 1'b1, 1'b0);
    send3(1'b0, 1'b1, 1'b1, 1'b0);
    check("bp_full_ready", int'(bit_ready), 0);
    send3(1'b1, 1'b0, 1'b0, 1'b0);
    check("bp_head_held", int'(out_value), 1);
    // Pop while full: the bit offered in the same cycle is not taken
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("bp_second_value", int'(out_value), 3);
    check("bp_ready_back", int'(bit_ready), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("bp_drained", int'(out_valid), 0);
    send3(1'b1, 1'b0, 1'b0, 1'b0);
    check("bp_third_value", int'(out_value), 4);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-word
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("rstmid_valid_in_rst", int'(out_valid), 0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("rstmid_valid_partial", int'(out_valid), 0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("rstmid_value", int'(out_value), 2);
    check("rstmid_reject", int'(reject_cnt), 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Saturation: five 7s on a 2-bit counter, then one more
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b1, 1'b1);
    check("sat_value", int'(s_reject_cnt), 3);
    check("sat_wide_value", int'(reject_cnt), 5);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1);
    check("sat_stays", int'(s_reject_cnt), 3);
    check("sat_wide_next", int'(reject_cnt), 6);

    // Uniformity soak with LFSR bits and random handshakes
    step(1'b1, 1'b0, 1'b0, 1'b0);
    soak_on = 1'b1;
    m_words = 0;
    lfsr = 16'hACE1;
    iter = 0;
    while (m_words < 6000 && iter < 60000) begin
      step(1'b0, ($urandom_range(9) != 0), lfsr[0], ($urandom_range(9) < 7));
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      iter++;
    end
    check("soak_completed", int'(m_words >= 6000), 1);
    for (int v = 0; v < Max; v++) check($sformatf("soak_seen_%0d", v), int'(hist[v] > 0), 1);
    check("soak_none_6", hist[6], 0);
    check("soak_none_7", hist[7], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rng_range_sampler.md
# rng_range_sampler

Downstream consumer of the LFSR random-bit stream. Packs successive non-overlapping bits into `WIDTH`-bit candidates and rejection-samples them so that accepted values are uniform over `0..MAX-1`. Buffers accepted values in a small first-word-fall-through FIFO behind a valid/ready port. Feeds game and display logic (dice, LED patterns) that need bounded random numbers rather than raw bits.

## Interface
- `WIDTH`, 3: bits per candidate word.
- `MAX`, 6: exclusive upper bound of output values; legal range 2..2**WIDTH.
- `DEPTH`, 2: output FIFO entries; power of two, at least 2.
- `CNT_W`, 16: width of the saturating reject counter.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `bit_in`  in  1  random bit from the LFSR.
- `bit_valid`  in  1  `bit_in` is meaningful this cycle; may be tied high.
- `bit_ready`  out  1  block accepts a bit this cycle; equals `!full`.
- `out_value`  out  `WIDTH`  FIFO head value.
- `out_valid`  out  1  FIFO not empty.
- `out_ready`  in  1  consumer takes `out_value` this cycle.
- `reject_cnt`  out  `CNT_W`  number of rejected candidates; saturates at all-ones.

## Operation
- A bit is accepted when `bit_valid && bit_ready`. Non-accepted cycles change nothing in the packer.
- Packer: shift register `sr[WIDTH-2:0]` plus bit counter `cnt` (0..WIDTH-1). Each accepted bit shifts in at the LSB, so the first bit of a word becomes the MSB.
- On the accepted bit with `cnt == WIDTH-1`, candidate = `{sr, bit_in}` and `cnt` wraps to 0.
  - Candidate < `MAX`: push into the FIFO.
  - Candidate >= `MAX`: discard; `reject_cnt` increments unless it is already all-ones.
- Bits are never reused between candidates.
- FIFO pop when `out_valid && out_ready`. `out_value` is undefined when `!out_valid`, but holds stable while valid and not popped.
- Push into a full FIFO cannot happen, because `bit_ready` is low while full.
- A pop while full raises `bit_ready` on the next cycle, not combinationally.
- Push and pop in the same cycle are allowed whenever the FIFO is non-full; occupancy is unchanged.
- Reset values: `cnt`=0, `sr`=0, FIFO empty, `out_valid`=0, `bit_ready`=1, `reject_cnt`=0.
- Reset mid-word discards the partial word. The next word starts with the first bit accepted after reset is released.
- Elaboration check: fail if `MAX < 2`, `MAX > 2**WIDTH`, or `DEPTH` is not a power of two >= 2.

## Timing
- Latency: `out_valid` rises at the same clock edge that samples the completing bit into an empty FIFO. Data is visible in the following cycle.
- Best-case throughput: one value per `WIDTH` accepted bits.
- `bit_ready` and `out_valid` are driven from registers only. There is no combinational path from `out_ready` or `bit_valid` to any output.
- `reject_cnt` updates on the edge that samples the rejecting bit.

## Structure
- Package `rng_pkg`:
  - default `WIDTH`, `MAX`, `DEPTH` localparams;
  - a `clog2`-derived pointer-width helper;
  - the `CNT_W` default.
- Sub-module `sync_fifo_fwft` (params `W`, `DEPTH`):
  - pointers with an extra wrap bit to distinguish full from empty;
  - `push`, `pop`, `din`, `dout`, `full`, `empty`, all with synchronous reset.
- Top level contains the packer, comparator, reject counter and handshake glue.

## Test plan
- **Basic pack:** defaults, `out_ready`=1, bits 1,0,1 → one value 5 with `out_valid` for one cycle; `reject_cnt`=0.
- **Rejection:** bits 1,1,1 then 0,1,0 → the first candidate (7) produces no output and `reject_cnt`=1; the second yields value 2.
- **Backpressure:** `out_ready`=0, bits 0,0,1, 0,1,1, 1,0,0 (values 1, 3, 4) → after two words `bit_ready`=0 and the 4 is held off. Raising `out_ready` pops 1 then 3 in order; `bit_ready` returns one cycle after the first pop; the 4 follows once its bits are resent.
- **Reset mid-word:** bits 1,1, pulse `rst` for one cycle, then bits 0,1,0 → output 2 only; `reject_cnt`=0; `out_valid` low during and after reset until the word completes.
- **Saturation:** `CNT_W`=2, 15 consecutive 1 bits (5 candidates of 7) → `reject_cnt` reads 3 and stays 3; no outputs.
- **Uniformity soak:** LFSR driving `bit_in` for 6000 words → each of values 0..5 appears; value 6 or 7 never appears on `out_value` while `out_valid`.
